// File: rtl/countdown_sequencer.sv
// Countdown sequencer: shows START_NUM..1 on the number sprite, then a GO phase,
// then pulses done back to the game-control FSM.
module countdown_sequencer #(
    parameter int unsigned TICKS_PER_DIGIT = 100_000_000,
    parameter int unsigned GO_TICKS        = 50_000_000,
    parameter int unsigned START_NUM       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    output logic [1:0] num,
    output logic       show,
    output logic       go,
    output logic       busy,
    output logic       done
);

    localparam int unsigned MAX_TICKS = (TICKS_PER_DIGIT > GO_TICKS) ? TICKS_PER_DIGIT : GO_TICKS;
    localparam int unsigned CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int unsigned NUM_W     = 2;

    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] GO_LAST    = CNT_W'(GO_TICKS - 1);
    localparam logic [NUM_W-1:0] FIRST_NUM  = NUM_W'(START_NUM);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_GO    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [NUM_W-1:0] num_q,   num_d;
    logic             done_q,  done_d;
    logic             show_q,  show_d;
    logic             go_q,    go_d;
    logic             busy_q,  busy_d;

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            done_q  <= 1'b0;
            show_q  <= 1'b0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            done_q  <= done_d;
            show_q  <= show_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; abort wins over everything, pause freezes COUNT/GO
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        done_d  = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            num_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_COUNT;
                        num_d   = FIRST_NUM;
                        cnt_d   = '0;
                    end
                end
                ST_COUNT: begin
                    if (!pause) begin
                        if (cnt_q == DIGIT_LAST) begin
                            cnt_d = '0;
                            if (num_q > NUM_W'(1)) begin
                                num_d = num_q - NUM_W'(1);
                            end else begin
                                state_d = ST_GO;
                                num_d   = '0;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_GO: begin
                    if (!pause) begin
                        if (cnt_q == GO_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    num_d   = '0;
                end
            endcase
        end
    end

    // Output flags decoded from the next state so they register alongside it
    always_comb begin
        show_d = (state_d == ST_COUNT);
        go_d   = (state_d == ST_GO);
        busy_d = (state_d != ST_IDLE);
    end

    assign num  = num_q;
    assign show = show_q;
    assign go   = go_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with TICKS_PER_DIGIT=4, GO_TICKS=2, START_NUM=3.
`timescale 1ns/1ps
module tb_countdown_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       pause;
    logic [1:0] num;
    logic       show;
    logic       go;
    logic       busy;
    logic       done;

    int unsigned n_checks;
    int unsigned n_errors;

    countdown_sequencer #(
        .TICKS_PER_DIGIT(4),
        .GO_TICKS       (2),
        .START_NUM      (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .pause(pause),
        .num  (num),
        .show (show),
        .go   (go),
        .busy (busy),
        .done (done)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all outputs against the unpaused reference timeline; e=0 means idle.
    // Reference (start accepted at edge 0): num 3 on 1-4, 2 on 5-8, 1 on 9-12,
    // go on 13-14, done on 15, idle afterwards.
    task automatic check_cycle(input string tag, input int e);
        int unsigned en, es, eg, eb, ed;
        en = 0; es = 0; eg = 0; eb = 0; ed = 0;
        if (e >= 1 && e <= 4)        en = 3;
        else if (e >= 5 && e <= 8)   en = 2;
        else if (e >= 9 && e <= 12)  en = 1;
        if (e >= 1 && e <= 12) es = 1;
        if (e == 13 || e == 14) eg = 1;
        if (e >= 1 && e <= 14) eb = 1;
        if (e == 15) ed = 1;
        check({tag, ".num"},  32'(num),  en);
        check({tag, ".show"}, 32'(show), es);
        check({tag, ".go"},   32'(go),   eg);
        check({tag, ".busy"}, 32'(busy), eb);
        check({tag, ".done"}, 32'(done), ed);
    endtask

    // One start pulse at edge 0, then ncyc observed cycles; optional pause window,
    // abort cycle and re-start cycle (0 disables each).
    task automatic run_seq(input string tag, input int ncyc, input int p_from, input int p_to,
                           input int abort_at, input int restart_at);
        int paused;
        bit aborted;
        paused  = 0;
        aborted = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            check_cycle($sformatf("%s.c%0d", tag, c), aborted ? 0 : c - paused);
            pause = (c >= p_from && c <= p_to && p_from > 0);
            if (pause) paused++;
            abort = (c == abort_at);
            if (abort) aborted = 1'b1;
            start = (c == restart_at);
            tick();
        end
        pause = 1'b0;
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;

        // Reset values
        #2;
        check_cycle("reset", 0);
        #10;
        rst_n = 1'b1;
        tick();
        check_cycle("post_reset", 0);

        // Basic countdown
        run_seq("basic", 17, 0, 0, 0, 0);

        // Pause for 3 cycles starting at cycle 3
        run_seq("pause", 20, 3, 5, 0, 0);

        // Abort during digit 2, then fresh start
        run_seq("abort", 12, 0, 0, 6, 0);
        run_seq("after_abort", 16, 0, 0, 0, 0);

        // start while busy is ignored
        run_seq("restart_busy", 17, 0, 0, 0, 5);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check_cycle($sformatf("start_abort.c%0d", c), 0);
            tick();
        end

        // start held high: done cycle accepts start, COUNT follows immediately
        start = 1'b1;
        tick();
        for (int c = 1; c <= 15; c++) begin
            if (c == 15) check_cycle("held.c15", 15);
            tick();
        end
        check("held.restart_num",  32'(num),  3);
        check("held.restart_show", 32'(show), 1);
        check("held.restart_done", 32'(done), 0);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_cycle("held.aborted", 0);

        // Asynchronous reset mid-cycle during GO
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 13; c++) tick();
        check("areset.go_before", 32'(go), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_cycle("areset.during", 0);
        #3;
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_cycle($sformatf("areset.idle%0d", c), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
